maze_tile_writer: RTL and testbench
===================================

# maze_tile_writer

Owns the 13×19 game-maze tile map. It writes bombs into the map, runs the cross-shaped explosion that clears bricks and bombs, and restores the level layout. The movement-validity checker and the maze drawer read tiles through this block's registered read port. It sits between the player/bomb controllers, which issue requests, and every consumer of maze occupancy.

## Interface
Parameters:
- RADIUS, 2: tiles probed in each direction during an explosion (1..6).
- X_ORIGIN, 15: screen X of maze tile column 0.
- Y_ORIGIN, 48: screen Y of maze tile row 0.

Ports:
- clk  in  1  system clock; one clock domain.
- resetN  in  1  reset, synchronous and active-low.
- level_load  in  1  pulse: reload the default map.
- bomb_placed  in  1  pulse: place a bomb under the player.
- player_topLeftX  in  11  player sprite top-left X in pixels.
- player_topLeftY  in  11  player sprite top-left Y in pixels.
- explode  in  1  pulse: explode the tile at explode_row/explode_col.
- explode_row  in  4  explosion centre row.
- explode_col  in  5  explosion centre column.
- rd_row  in  4  read-port row.
- rd_col  in  5  read-port column.
- rd_data  out  2  tile code at the read address; registered.
- busy  out  1  explosion in progress.
- expl_done  out  1  one-cycle pulse at the end of an explosion.
- bomb_accepted  out  1  one-cycle pulse when a bomb is written.
- brick_destroyed  out  1  one-cycle pulse for each brick cleared.

## Operation
- Tile codes: 0 empty, 1 hard wall, 2 brick, 3 bomb.
- Default map, with r = row 0..12 and c = col 0..18:
  - code 1 if r and c are both odd;
  - else code 2 if r and c are both even and r+c ≥ 4;
  - else code 0.
- Reset (resetN=0 at a clock edge) and level_load both:
  - load the default map;
  - force the FSM to IDLE;
  - clear all outputs to 0, including rd_data.
- Bomb placement:
  - col = (player_topLeftX − X_ORIGIN + 16) >> 5; row = (player_topLeftY − Y_ORIGIN + 16) >> 5. This is the tile under the sprite centre.
  - Ignore the request if player_topLeftX < X_ORIGIN, player_topLeftY < Y_ORIGIN, row > 12 or col > 18.
  - Write code 3 only if the tile is 0. When written, pulse bomb_accepted in the same edge.
  - Requests are accepted only in IDLE and ignored while busy.
- Explosion FSM states: IDLE → CENTER → UP → DOWN → LEFT → RIGHT → DONE → IDLE.
  - IDLE: explode=1 with an in-range centre latches the centre and goes to CENTER. An out-of-range centre is ignored.
  - CENTER, 1 cycle: the centre tile is cleared to 0 unless it is code 1. If the centre was code 2, pulse brick_destroyed.
  - UP/DOWN/LEFT/RIGHT: one probe per cycle at distance d = 1..RADIUS.
    - Out of grid or code 1: no write; the direction ends.
    - Code 2: write 0, pulse brick_destroyed; the direction ends.
    - Code 0 or 3: write 0; continue to d+1.
    - The direction also ends after d = RADIUS.
  - DONE, 1 cycle: expl_done=1, then back to IDLE.
  - busy=1 in every state except IDLE.
- Bombs hit by the blast are cleared and do not chain; the bomb controller owns chaining.
- Priority within one cycle: resetN=0, then level_load, then explode, then bomb_placed.
  - If explode and bomb_placed arrive together in IDLE, the bomb is dropped.
  - level_load during an explosion aborts it. No expl_done is generated.
- Read port: rd_data is the registered value of map[rd_row][rd_col]. An out-of-range address returns 1 (wall).

## Timing
- rd_data latency is 1 cycle. It reflects writes made on earlier edges; a write on the same edge is not visible.
- Bomb write and bomb_accepted appear on the edge that samples bomb_placed.
- Explosion:
  - explode is sampled at edge E.
  - busy rises after E and stays high for 1 + P + 1 cycles, where P is the total probe count (each stopping probe costs 1 cycle).
  - expl_done is high during the last busy cycle.
- A new explode is accepted on the first edge where the FSM is in IDLE.
- Each brick_destroyed pulse lasts one cycle and coincides with its write.

## Test plan
- Reset, then read: (0,0) → 0; (1,1) → 1; (2,2) → 2; (0,2) → 0; (12,18) → 2; (13,0) → 1 (out of range).
- player_topLeftX=15, Y=48, bomb_placed → bomb_accepted pulse; (0,0) reads 3. A repeat request → no pulse. X=10 → ignored.
- explode at (2,3):
  - Cleared: (2,2) and (2,4), each with its own brick_destroyed pulse.
  - Unchanged: (1,3)=1, (3,3)=1, (2,6)=2.
  - busy lasts 6 cycles; expl_done is high in the 6th.
- Bomb at (0,0), then explode (0,0):
  - Afterwards (0,0), (1,0), (2,0), (0,1) and (0,2) all read 0.
  - busy lasts 8 cycles; there are no brick pulses.
- Simultaneous and mid-operation events:
  - bomb_placed during busy → ignored.
  - explode together with bomb_placed → only the explosion runs.
  - level_load at the 3rd busy cycle → busy drops next cycle, (2,2) reads 2, and no expl_done.
- resetN=0 for one edge during an explosion → the map returns to default and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/maze_tile_writer.sv
// 13x19 maze tile map: bomb writes, cross-shaped explosion sweep, level reload.
// The read port is registered, so rd_data has 1 cycle of latency; bombs are dropped while an explosion is busy.
module maze_tile_writer #(
    parameter int RADIUS   = 2,
    parameter int X_ORIGIN = 15,
    parameter int Y_ORIGIN = 48
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        level_load,
    input  logic        bomb_placed,
    input  logic [10:0] player_topLeftX,
    input  logic [10:0] player_topLeftY,
    input  logic        explode,
    input  logic [3:0]  explode_row,
    input  logic [4:0]  explode_col,
    input  logic [3:0]  rd_row,
    input  logic [4:0]  rd_col,
    output logic [1:0]  rd_data,
    output logic        busy,
    output logic        expl_done,
    output logic        bomb_accepted,
    output logic        brick_destroyed
);
    localparam int ROWS = 13;
    localparam int COLS = 19;
    localparam logic [1:0] T_EMPTY = 2'd0;
    localparam logic [1:0] T_WALL  = 2'd1;
    localparam logic [1:0] T_BRICK = 2'd2;
    localparam logic [1:0] T_BOMB  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CENTER, S_UP, S_DOWN, S_LEFT, S_RIGHT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  map_q [ROWS][COLS];
    logic [3:0]  cr_q, cr_d;
    logic [4:0]  cc_q, cc_d;
    logic [2:0]  d_q, d_d;
    logic [1:0]  rd_data_q;
    logic        bomb_acc_q, bomb_acc_d;
    logic        brick_q, brick_d;

    logic        wr_en;
    logic [3:0]  wr_row;
    logic [4:0]  wr_col;
    logic [1:0]  wr_dat;

    logic [11:0] bx_off, by_off, bx_sh, by_sh;
    logic        bomb_in;
    logic [1:0]  bomb_tile;
    logic [6:0]  pr, pc;
    logic        probe_oob;
    logic [1:0]  probe_tile;
    logic        rd_in_range;

    function automatic logic [1:0] default_tile(input int r, input int c);
        if ((r % 2 == 1) && (c % 2 == 1))                 return T_WALL;
        if ((r % 2 == 0) && (c % 2 == 0) && (r + c >= 4)) return T_BRICK;
        return T_EMPTY;
    endfunction

    function automatic state_t next_dir(input state_t s);
        case (s)
            S_UP:    return S_DOWN;
            S_DOWN:  return S_LEFT;
            S_LEFT:  return S_RIGHT;
            default: return S_DONE;
        endcase
    endfunction

    // Tile under the sprite centre: offset by half a 32-pixel tile before dividing.
    assign bx_off  = {1'b0, player_topLeftX} - 12'(X_ORIGIN) + 12'd16;
    assign by_off  = {1'b0, player_topLeftY} - 12'(Y_ORIGIN) + 12'd16;
    assign bx_sh   = bx_off >> 5;
    assign by_sh   = by_off >> 5;
    assign bomb_in = (player_topLeftX >= 11'(X_ORIGIN)) && (player_topLeftY >= 11'(Y_ORIGIN)) &&
                     (by_sh <= 12'd12) && (bx_sh <= 12'd18);
    assign bomb_tile = bomb_in ? map_q[by_sh[3:0]][bx_sh[4:0]] : T_WALL;

    always_comb begin
        pr = {3'b000, cr_q};
        pc = {2'b00, cc_q};
        case (state_q)
            S_UP:    pr = {3'b000, cr_q} - {4'b0000, d_q};
            S_DOWN:  pr = {3'b000, cr_q} + {4'b0000, d_q};
            S_LEFT:  pc = {2'b00, cc_q} - {4'b0000, d_q};
            S_RIGHT: pc = {2'b00, cc_q} + {4'b0000, d_q};
            default: ;
        endcase
    end

    // Negative coordinates wrap to large values, so one compare covers both edges.
    assign probe_oob  = (pr > 7'd12) || (pc > 7'd18);
    assign probe_tile = probe_oob ? T_WALL : map_q[pr[3:0]][pc[4:0]];

    always_comb begin
        state_d    = state_q;
        cr_d       = cr_q;
        cc_d       = cc_q;
        d_d        = d_q;
        wr_en      = 1'b0;
        wr_row     = pr[3:0];
        wr_col     = pc[4:0];
        wr_dat     = T_EMPTY;
        bomb_acc_d = 1'b0;
        brick_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (explode) begin
                    if ((explode_row <= 4'd12) && (explode_col <= 5'd18)) begin
                        cr_d    = explode_row;
                        cc_d    = explode_col;
                        state_d = S_CENTER;
                    end
                end else if (bomb_placed && bomb_in && (bomb_tile == T_EMPTY)) begin
                    wr_en      = 1'b1;
                    wr_row     = by_sh[3:0];
                    wr_col     = bx_sh[4:0];
                    wr_dat     = T_BOMB;
                    bomb_acc_d = 1'b1;
                end
            end
            S_CENTER: begin
                wr_en   = (probe_tile != T_WALL);
                brick_d = (probe_tile == T_BRICK);
                d_d     = 3'd1;
                state_d = S_UP;
            end
            S_UP, S_DOWN, S_LEFT, S_RIGHT: begin
                wr_en   = (probe_tile != T_WALL);
                brick_d = (probe_tile == T_BRICK);
                if ((probe_tile == T_WALL) || (probe_tile == T_BRICK) || (d_q == 3'(RADIUS))) begin
                    d_d     = 3'd1;
                    state_d = next_dir(state_q);
                end else begin
                    d_d = d_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_in_range = (rd_row <= 4'd12) && (rd_col <= 5'd18);

    always_ff @(posedge clk) begin
        if (!resetN || level_load) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    map_q[r][c] <= default_tile(r, c);
                end
            end
            state_q    <= S_IDLE;
            cr_q       <= '0;
            cc_q       <= '0;
            d_q        <= '0;
            rd_data_q  <= '0;
            bomb_acc_q <= 1'b0;
            brick_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                map_q[wr_row][wr_col] <= wr_dat;
            end
            state_q    <= state_d;
            cr_q       <= cr_d;
            cc_q       <= cc_d;
            d_q        <= d_d;
            rd_data_q  <= rd_in_range ? map_q[rd_row][rd_col] : T_WALL;
            bomb_acc_q <= bomb_acc_d;
            brick_q    <= brick_d;
        end
    end

    assign rd_data         = rd_data_q;
    assign busy            = (state_q != S_IDLE);
    assign expl_done       = (state_q == S_DONE);
    assign bomb_accepted   = bomb_acc_q;
    assign brick_destroyed = brick_q;

endmodule

// File: tb/tb_maze_tile_writer.sv
// Bench for maze_tile_writer: directed scenarios plus random bombs/explosions against a tile-map model.
module tb_maze_tile_writer;
    localparam int RADIUS = 2;
    localparam int XO     = 15;
    localparam int YO     = 48;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        level_load = 1'b0;
    logic        bomb_placed = 1'b0;
    logic [10:0] player_topLeftX = '0;
    logic [10:0] player_topLeftY = '0;
    logic        explode = 1'b0;
    logic [3:0]  explode_row = '0;
    logic [4:0]  explode_col = '0;
    logic [3:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic [1:0]  rd_data;
    logic        busy, expl_done, bomb_accepted, brick_destroyed;

    int checks = 0;
    int failures = 0;
    int mm [13][19];

    maze_tile_writer #(.RADIUS(RADIUS), .X_ORIGIN(XO), .Y_ORIGIN(YO)) dut (
        .clk(clk), .resetN(resetN), .level_load(level_load), .bomb_placed(bomb_placed),
        .player_topLeftX(player_topLeftX), .player_topLeftY(player_topLeftY),
        .explode(explode), .explode_row(explode_row), .explode_col(explode_col),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .busy(busy),
        .expl_done(expl_done), .bomb_accepted(bomb_accepted), .brick_destroyed(brick_destroyed)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dflt(input int r, input int c);
        if (r % 2 == 1 && c % 2 == 1) return 1;
        if (r % 2 == 0 && c % 2 == 0 && r + c >= 4) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 19; c++)
                mm[r][c] = dflt(r, c);
    endfunction

    function automatic bit in_grid(input int r, input int c);
        return (r >= 0 && r < 13 && c >= 0 && c < 19);
    endfunction

    // Returns probe count p (-1 when the centre is rejected) and brick count b.
    function automatic void model_explode(input int r, input int c, output int p, output int b);
        int dr, dc, rr, cc;
        p = 0;
        b = 0;
        if (!in_grid(r, c)) begin
            p = -1;
            return;
        end
        if (mm[r][c] != 1) begin
            if (mm[r][c] == 2) b++;
            mm[r][c] = 0;
        end
        for (int dir = 0; dir < 4; dir++) begin
            dr = (dir == 0) ? -1 : (dir == 1) ? 1 : 0;
            dc = (dir == 2) ? -1 : (dir == 3) ? 1 : 0;
            for (int d = 1; d <= RADIUS; d++) begin
                p++;
                rr = r + dr * d;
                cc = c + dc * d;
                if (!in_grid(rr, cc) || mm[rr][cc] == 1) break;
                if (mm[rr][cc] == 2) begin
                    mm[rr][cc] = 0;
                    b++;
                    break;
                end
                mm[rr][cc] = 0;
            end
        end
    endfunction

    task automatic rd_chk(input int r, input int c, input int exp);
        rd_row = 4'(r);
        rd_col = 5'(c);
        tick();
        chk($sformatf("rd(%0d,%0d)", r, c), 32'(rd_data), exp);
    endtask

    task automatic check_map();
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 19; c++)
                rd_chk(r, c, mm[r][c]);
    endtask

    task automatic do_bomb(input int x, input int y);
        int col, row, exp_acc;
        exp_acc = 0;
        if (x >= XO && y >= YO) begin
            col = (x - XO + 16) / 32;
            row = (y - YO + 16) / 32;
            if (row <= 12 && col <= 18 && mm[row][col] == 0) begin
                mm[row][col] = 3;
                exp_acc = 1;
            end
        end
        player_topLeftX = 11'(x);
        player_topLeftY = 11'(y);
        bomb_placed = 1'b1;
        tick();
        bomb_placed = 1'b0;
        chk($sformatf("bomb_accepted x=%0d y=%0d", x, y), 32'(bomb_accepted), exp_acc);
        tick();
        chk("bomb_accepted_one_cycle", 32'(bomb_accepted), 0);
    endtask

    // with_bomb also raises bomb_placed on the explode edge at an empty tile (11,0).
    task automatic run_explode(input int r, input int c, input bit with_bomb,
                               output int cnt, output int bricks);
        int p, b, dones, last_done;
        model_explode(r, c, p, b);
        explode_row = 4'(r);
        explode_col = 5'(c);
        explode = 1'b1;
        if (with_bomb) begin
            player_topLeftX = 11'(XO);
            player_topLeftY = 11'(YO + 11 * 32);
            bomb_placed = 1'b1;
        end
        tick();
        explode = 1'b0;
        bomb_placed = 1'b0;
        if (with_bomb) chk("bomb_with_explode", 32'(bomb_accepted), 0);
        cnt = 0; bricks = 0; dones = 0; last_done = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            bricks += int'(brick_destroyed);
            dones += int'(expl_done);
            last_done = int'(expl_done);
            tick();
        end
        chk($sformatf("busy_cycles(%0d,%0d)", r, c), cnt, (p < 0) ? 0 : p + 2);
        chk($sformatf("bricks(%0d,%0d)", r, c), bricks, b);
        chk($sformatf("expl_done_count(%0d,%0d)", r, c), dones, (p < 0) ? 0 : 1);
        if (p >= 0) chk("expl_done_last_cycle", last_done, 1);
    endtask

    initial begin
        int cnt, bricks, op;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expl_done", 32'(expl_done), 0);
        chk("rst_bomb_accepted", 32'(bomb_accepted), 0);
        chk("rst_brick", 32'(brick_destroyed), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        resetN = 1'b1;

        // Default map reads, including out-of-range addresses
        rd_chk(0, 0, 0);
        rd_chk(1, 1, 1);
        rd_chk(2, 2, 2);
        rd_chk(0, 2, 0);
        rd_chk(12, 18, 2);
        rd_chk(13, 0, 1);
        rd_chk(0, 19, 1);
        rd_chk(15, 31, 1);

        // Bomb placement
        do_bomb(15, 48);
        rd_chk(0, 0, 3);
        do_bomb(15, 48);
        do_bomb(10, 48);
        do_bomb(15 + 4 * 32 + 15, 48 + 3 * 32 - 16);
        rd_chk(3, 4, mm[3][4]);

        // Explosion at (2,3): two bricks, walls intact
        run_explode(2, 3, 1'b0, cnt, bricks);
        chk("expl23_busy6", cnt, 6);
        chk("expl23_bricks2", bricks, 2);
        rd_chk(2, 2, 0);
        rd_chk(2, 4, 0);
        rd_chk(1, 3, 1);
        rd_chk(3, 3, 1);
        rd_chk(2, 6, 2);

        // Explosion on the bomb at the corner
        run_explode(0, 0, 1'b0, cnt, bricks);
        chk("expl00_busy8", cnt, 8);
        chk("expl00_bricks0", bricks, 0);
        rd_chk(0, 0, 0);
        rd_chk(1, 0, 0);
        rd_chk(2, 0, 0);
        rd_chk(0, 1, 0);
        rd_chk(0, 2, 0);

        // Bomb request while busy is ignored
        model_explode(2, 10, cnt, bricks);
        explode_row = 4'd2;
        explode_col = 5'd10;
        explode = 1'b1;
        tick();
        explode = 1'b0;
        player_topLeftX = 11'(XO);
        player_topLeftY = 11'(YO + 11 * 32);
        bomb_placed = 1'b1;
        tick();
        bomb_placed = 1'b0;
        chk("bomb_while_busy", 32'(bomb_accepted), 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("busy_ends", 32'(busy), 0);
        rd_chk(11, 0, 0);

        // Explode and bomb in the same cycle: only the explosion runs
        run_explode(4, 4, 1'b1, cnt, bricks);
        check_map();

        // level_load in the 3rd busy cycle aborts the explosion
        explode_row = 4'd6;
        explode_col = 5'd8;
        explode = 1'b1;
        tick();
        explode = 1'b0;
        chk("abort_busy1", 32'(busy), 1);
        tick();
        tick();
        chk("abort_busy3", 32'(busy), 1);
        chk("abort_no_done_yet", 32'(expl_done), 0);
        level_load = 1'b1;
        tick();
        level_load = 1'b0;
        model_reset();
        chk("abort_busy_drop", 32'(busy), 0);
        chk("abort_no_done", 32'(expl_done), 0);
        tick();
        chk("abort_no_done_later", 32'(expl_done), 0);
        rd_chk(2, 2, 2);

        // Reset during an explosion
        explode_row = 4'd2;
        explode_col = 5'd3;
        explode = 1'b1;
        tick();
        explode = 1'b0;
        tick();
        tick();
        resetN = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_expl_done", 32'(expl_done), 0);
        chk("midrst_bomb_accepted", 32'(bomb_accepted), 0);
        chk("midrst_brick", 32'(brick_destroyed), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        resetN = 1'b1;
        model_reset();
        check_map();

        // Random mix of bombs, explosions and level loads
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 11));
            if (op == 0) begin
                level_load = 1'b1;
                tick();
                level_load = 1'b0;
                model_reset();
                chk("rand_level_load_busy", 32'(busy), 0);
            end else if (op <= 5) begin
                do_bomb(int'($urandom_range(5, 640)), int'($urandom_range(40, 470)));
            end else begin
                run_explode(int'($urandom_range(0, 14)), int'($urandom_range(0, 20)), 1'b0, cnt, bricks);
            end
            if (i == 40) check_map();
        end
        check_map();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
